botones_comandos: RTL and testbench

- Front-end command generator that drives the button-command inputs of the main control gate (aumf, bajaf, aumC, bajaC, MODO, MRst).
- Takes six raw, bouncy, asynchronous pushbuttons and synchronizes and debounces each one.
- Emits a clean one-cycle command pulse per press.
- The four up/down frequency and current commands also auto-repeat while held.

---
 rtl/botones_comandos.sv | 169 ++++++++++++++++
 tb/tb_botones_comandos.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/botones_comandos.sv
// Six-button front end: 2-flop sync, per-channel debounce FSM with auto-repeat
// on the four up/down channels, and registered output arbitration.
module botones_comandos #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned REP_CYCLES  = 5000000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_aumf,
  input  logic btn_bajaf,
  input  logic btn_aumC,
  input  logic btn_bajaC,
  input  logic btn_modo,
  input  logic btn_rst,
  output logic aumf_o,
  output logic bajaf_o,
  output logic aumC_o,
  output logic bajaC_o,
  output logic MODO_o,
  output logic MRst_o
);

  localparam int unsigned NCH     = 6;
  localparam int unsigned CH_AUMF  = 0;
  localparam int unsigned CH_BAJAF = 1;
  localparam int unsigned CH_AUMC  = 2;
  localparam int unsigned CH_BAJAC = 3;
  localparam int unsigned CH_MODO  = 4;
  localparam int unsigned CH_RST   = 5;

  localparam logic [NCH-1:0]   REPEAT_MASK = 6'b001111;
  localparam logic [CNT_W-1:0] DEB_LIM     = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LIM    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_LIM     = CNT_W'(REP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  logic [NCH-1:0]   btn_raw;
  logic [NCH-1:0]   sync1_q, sync2_q;
  logic [NCH-1:0]   phase_q, phase_d;
  logic [NCH-1:0]   req_q, req_d;
  logic [NCH-1:0]   out_q, out_d;
  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];

  assign btn_raw = {btn_rst, btn_modo, btn_bajaC, btn_aumC, btn_bajaf, btn_aumf};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // Synchronizers, channel state, request and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      phase_q <= '0;
      req_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      phase_q <= phase_d;
      req_q   <= req_d;
      out_q   <= out_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-channel debounce / repeat next-state; phase_q set means first repeat done
  always_comb begin
    phase_d = phase_q;
    req_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i]) begin
            state_d[i] = DEB_PRESS;
            cnt_d[i]   = CNT_ONE;
          end
        end
        DEB_PRESS: begin
          if (cnt_q[i] == DEB_LIM) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
            req_d[i]   = 1'b1;
          end else if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d[i] = DEB_REL;
            cnt_d[i]   = CNT_ONE;
          end else if (REPEAT_MASK[i]) begin
            if (cnt_q[i] == (phase_q[i] ? REP_LIM : HOLD_LIM)) begin
              cnt_d[i]   = '0;
              phase_d[i] = 1'b1;
              req_d[i]   = 1'b1;
            end else begin
              cnt_d[i] = sat_inc(cnt_q[i]);
            end
          end
        end
        DEB_REL: begin
          if (cnt_q[i] == DEB_LIM) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (sync2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Reset command wins outright; opposing up/down requests cancel each other
  always_comb begin
    out_d = '0;
    if (req_q[CH_RST]) begin
      out_d[CH_RST] = 1'b1;
    end else begin
      out_d[CH_AUMF]  = req_q[CH_AUMF]  & ~req_q[CH_BAJAF];
      out_d[CH_BAJAF] = req_q[CH_BAJAF] & ~req_q[CH_AUMF];
      out_d[CH_AUMC]  = req_q[CH_AUMC]  & ~req_q[CH_BAJAC];
      out_d[CH_BAJAC] = req_q[CH_BAJAC] & ~req_q[CH_AUMC];
      out_d[CH_MODO]  = req_q[CH_MODO];
    end
  end

  assign aumf_o  = out_q[CH_AUMF];
  assign bajaf_o = out_q[CH_BAJAF];
  assign aumC_o  = out_q[CH_AUMC];
  assign bajaC_o = out_q[CH_BAJAC];
  assign MODO_o  = out_q[CH_MODO];
  assign MRst_o  = out_q[CH_RST];

endmodule

// File: tb/tb_botones_comandos.sv
// Scoreboarded bench for botones_comandos: directed scenarios plus random
// button activity, checked against a level/streak behavioural model.
module tb_botones_comandos;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 8;
  localparam int unsigned CW   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] btn = '0;
  logic aumf_o, bajaf_o, aumC_o, bajaC_o, MODO_o, MRst_o;

  botones_comandos #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REP_CYCLES(REP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_aumf(btn[0]), .btn_bajaf(btn[1]), .btn_aumC(btn[2]),
    .btn_bajaC(btn[3]), .btn_modo(btn[4]), .btn_rst(btn[5]),
    .aumf_o(aumf_o), .bajaf_o(bajaf_o), .aumC_o(aumC_o),
    .bajaC_o(bajaC_o), .MODO_o(MODO_o), .MRst_o(MRst_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  vec;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         log_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Model: accepted level per button, length of the current disagreeing run,
  // hold timer since the last pulse, and whether the first repeat happened.
  bit          level  [6];
  int unsigned streak [6];
  int unsigned timer  [6];
  bit          rep_on [6];
  logic [5:0]  sh1 = '0, sh2 = '0;
  localparam logic [5:0] REPEATS = 6'b001111;

  always @(posedge clk) begin
    logic [5:0] req, s, v;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        level[i] = 0; streak[i] = 0; timer[i] = 0; rep_on[i] = 0;
      end
      sh1 = '0; sh2 = '0;
      exp_q.delete();
    end else begin
      s = sh2;
      req = '0;
      for (int i = 0; i < 6; i++) begin
        if (!level[i]) begin
          if (streak[i] == DEB) begin
            level[i] = 1; streak[i] = 0; timer[i] = 0; rep_on[i] = 0; req[i] = 1'b1;
          end else begin
            streak[i] = s[i] ? streak[i] + 1 : 0;
          end
        end else if (streak[i] == 0) begin
          if (!s[i]) streak[i] = 1;
          else if (REPEATS[i]) begin
            if (timer[i] == (rep_on[i] ? REP : HOLD)) begin
              req[i] = 1'b1; timer[i] = 0; rep_on[i] = 1;
            end else timer[i]++;
          end
        end else begin
          if (streak[i] == DEB) begin level[i] = 0; streak[i] = 0; end
          else if (s[i]) begin streak[i] = 0; timer[i] = 0; end
          else streak[i]++;
        end
      end
      sh2 = sh1;
      sh1 = btn;
      if (req[5]) v = 6'b100000;
      else v = {1'b0, req[4], req[3] & ~req[2], req[2] & ~req[3],
                req[1] & ~req[0], req[0] & ~req[1]};
      if (v != 0) exp_q.push_back('{cyc + 1, v});
    end
  end

  // Monitor: pops the expected pulse due this cycle, flags any extra pulse
  always @(negedge clk) begin
    logic [5:0] act;
    ev_t e;
    act = {MRst_o, MODO_o, bajaC_o, aumC_o, bajaf_o, aumf_o};
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missed_pulse cyc=%0d got none required %b", e.cyc, e.vec);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (act != e.vec) begin
          n_bad++;
          $display("FAIL pulse_vec cyc=%0d got %b required %b", cyc, act, e.vec);
        end
      end else if (act != 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pulse cyc=%0d got %b required 000000", cyc, act);
      end
      if (act != 0) log_q.push_back('{cyc, act});
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int count_pulses(input int b, input int unsigned from, input int unsigned to);
    int n = 0;
    foreach (log_q[k]) if (log_q[k].cyc >= from && log_q[k].cyc <= to && log_q[k].vec[b]) n++;
    return n;
  endfunction

  function automatic int count_any(input int unsigned from, input int unsigned to);
    int n = 0;
    foreach (log_q[k]) if (log_q[k].cyc >= from && log_q[k].cyc <= to) n++;
    return n;
  endfunction

  function automatic int first_pulse(input int b, input int unsigned from);
    foreach (log_q[k]) if (log_q[k].cyc >= from && log_q[k].vec[b]) return int'(log_q[k].cyc - from);
    return -1;
  endfunction

  function automatic int vec_at(input int unsigned c);
    foreach (log_q[k]) if (log_q[k].cyc == c) return int'(log_q[k].vec);
    return 0;
  endfunction

  function automatic int outs_now();
    return int'({MRst_o, MODO_o, bajaC_o, aumC_o, bajaf_o, aumf_o});
  endfunction

  // Press: drive mask for n cycles starting at the next edge, return that edge
  task automatic press(input logic [5:0] mask, input int n, output int unsigned e);
    @(negedge clk);
    btn = mask;
    e = cyc + 1;
    repeat (n) @(negedge clk);
    btn = '0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e, r, t0;
    logic [5:0] bseq;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_now(), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    press(6'b000001, 10, e);
    check("clean_latency", first_pulse(0, e), 7);
    check("clean_count", count_any(e, cyc), 1);

    bseq = 6'b101101;
    @(negedge clk);
    e = cyc + 1;
    for (int k = 0; k < 12; k++) begin
      btn = (k < 6) ? {2'b00, bseq[k], 3'b000} : 6'b001000;
      @(negedge clk);
    end
    btn = '0;
    repeat (20) @(negedge clk);
    check("bounce_latency", first_pulse(3, e), 12);
    check("bounce_count", count_any(e, cyc), 1);

    press(6'b000100, 50, e);
    check("rep_edge7", (vec_at(e + 7) >> 2) & 1, 1);
    check("rep_edge28", (vec_at(e + 28) >> 2) & 1, 1);
    check("rep_edge37", (vec_at(e + 37) >> 2) & 1, 1);
    check("rep_edge46", (vec_at(e + 46) >> 2) & 1, 1);
    check("rep_count", count_pulses(2, e, cyc), 4);

    press(6'b010000, 60, e);
    check("modo_count", count_pulses(4, e, cyc), 1);

    press(6'b000011, 30, e);
    check("conflict_aumf", count_pulses(0, e, cyc), 0);
    check("conflict_bajaf", count_pulses(1, e, cyc), 0);

    press(6'b000101, 10, e);
    check("same_cycle_vec", vec_at(e + 7), 6'b000101);

    press(6'b100100, 35, e);
    check("rst_priority_vec", vec_at(e + 7), 6'b100000);
    check("rst_then_repeat", (vec_at(e + 28) >> 2) & 1, 1);
    check("rst_count", count_pulses(5, e, cyc), 1);

    @(negedge clk);
    btn = 6'b000100;
    e = cyc + 1;
    while (cyc < e + 3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", outs_now(), 0);
    repeat (2) @(negedge clk);
    check("reset_held_outputs", outs_now(), 0);
    rst_n = 1'b1;
    r = cyc + 1;
    repeat (12) @(negedge clk);
    check("post_reset_latency", first_pulse(2, r), 7);
    btn = '0;
    repeat (20) @(negedge clk);

    t0 = cyc;
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      btn = 6'($urandom);
      if ($urandom_range(0, 3) != 0) btn[5] = 1'b0;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    btn = '0;
    repeat (40) @(negedge clk);
    check("random_drained", exp_q.size(), 0);
    check("random_activity", (count_any(t0, cyc) > 0) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
